// File: rtl/oam_dma_if.sv
// -----------------------------------------------------------------------------
// oam_dma_if -- one arbiter slot of the CPU system bus.
//
// Handshake: the initiator raises bus_req and presents bus_addr/bus_we/bus_dout;
// a transfer happens on a rising clk edge where bus_req and bus_rdy are both 1.
// While bus_rdy is 0 the initiator holds address, write enable and data stable.
// bus_din is valid in any cycle where a read (bus_we=0) is granted.
//
// Signals:
//   bus_req  initiator -> arbiter  request for the bus
//   bus_rdy  arbiter -> initiator  grant; slot owns the bus this cycle
//   bus_addr initiator -> bus      16-bit address
//   bus_we   initiator -> bus      write enable
//   bus_dout initiator -> bus      write data
//   bus_din  bus -> initiator      read data
// -----------------------------------------------------------------------------
interface oam_dma_if;
    logic        bus_req;
    logic        bus_rdy;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;

    modport master (
        output bus_req,
        output bus_addr,
        output bus_we,
        output bus_dout,
        input  bus_rdy,
        input  bus_din
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        input  bus_we,
        input  bus_dout,
        output bus_rdy,
        output bus_din
    );
endinterface

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma -- sprite DMA engine. A write to $4014 (delivered as trig + trig_page)
// copies LEN bytes from CPU page {trig_page,00..FF} to the OAM data port DST,
// one read followed by one write per byte, through a single arbiter slot.
//
// Ports:
//   clk        system (CPU) clock, rising edge
//   reset      asynchronous active-high reset; aborts any transfer silently
//   trig       one-cycle pulse: CPU wrote $4014
//   trig_page  source page captured with trig
//   busy       high from the cycle after trig until DONE completes
//   done       one-cycle completion pulse
//   dbg_state  current FSM state encoding (observation only)
//   bus        initiator side of the arbiter slot (oam_dma_if.master)
// -----------------------------------------------------------------------------
module oam_dma #(
    parameter int          LEN = 256,
    parameter logic [15:0] DST = 16'h2004
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trig,
    input  logic [7:0] trig_page,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state,
    oam_dma_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_DUMMY = 3'd2,
        S_ALIGN = 3'd3,
        S_READ  = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [8:0] LAST_IDX = 9'(LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [8:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        phase_q;

    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Next-state and datapath. Every transition out of a bus-owning state is
    // qualified by bus_rdy, so a preempted cycle leaves everything untouched.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    page_d  = trig_page;
                    idx_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.bus_rdy) state_d = S_DUMMY;
            end
            S_DUMMY: begin
                // A halt that lands on a put cycle needs one more idle cycle
                // so that reads always start on a get cycle.
                if (bus.bus_rdy) state_d = phase_q ? S_ALIGN : S_READ;
            end
            S_ALIGN: begin
                if (bus.bus_rdy) state_d = S_READ;
            end
            S_READ: begin
                if (bus.bus_rdy) begin
                    data_d  = bus.bus_din;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.bus_rdy) begin
                    idx_d   = idx_q + 9'd1;
                    state_d = (idx_q == LAST_IDX) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next state so the
    // outputs themselves come straight from flops.
    always_comb begin
        req_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        we_d   = (state_d == S_WRITE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        case (state_d)
            S_READ:         addr_d = {page_d, idx_d[7:0]};  // low byte wraps inside the page
            S_IDLE, S_DONE: addr_d = '0;
            default:        addr_d = DST;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            page_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            phase_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            phase_q <= ~phase_q;  // CPU get/put cycle, free running
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.bus_req  = req_q;
    assign bus.bus_we   = we_q;
    assign bus.bus_addr = addr_q;
    assign bus.bus_dout = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma -- bench for oam_dma. A table of transfer scenarios is applied in a
// loop; a hand-written sequence covers reset in the middle of a transfer, and a
// few transfers run with random page and random grant.
// Memory model: byte at address a = a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02, so page
// $02 holds i^5A and every other page holds different data.
// -----------------------------------------------------------------------------
module tb_oam_dma;

    localparam logic [15:0] DST = 16'h2004;

    typedef struct {
        logic [7:0] page;
        bit         odd;       // trigger sampled on an odd cycle count -> ALIGN
        int         stall_r;   // read index to stall 5 cycles (-1: none)
        int         stall_w;   // write index to stall 5 cycles (-1: none)
        bit         retrig;    // fire a second trig (page 07) at read idx 100
        bit         rnd;       // random grant, timing not checked
        int         exp_busy;  // cycles with busy=1
        int         exp_first; // cycles from trig edge to first READ
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       trig;
    logic [7:0] trig_page;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;
    logic       rdy;
    int         cyc;
    int         n_checks = 0;
    int         n_err = 0;
    vec_t       vecs[6];

    oam_dma_if bif();

    oam_dma #(.LEN(256), .DST(DST)) dut (
        .clk       (clk),
        .reset     (reset),
        .trig      (trig),
        .trig_page (trig_page),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state),
        .bus       (bif)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    // cyc parity equals the DUT's get/put phase
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
    endfunction

    assign bif.bus_rdy = rdy;
    assign bif.bus_din = src_byte(bif.bus_addr);

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full transfer: trigger, drive the grant, observe every bus cycle and
    // compare the byte stream with the expected copy of the source page.
    task automatic run_xfer(input vec_t v, input string tag);
        int busy_n = 0, done_n = 0, rd_n = 0, wr_n = 0;
        int bad_rd = 0, bad_wr = 0, bad_hold = 0, first = -1, steps = 0, stall_left = 0;
        bit st_r = 0, st_w = 0, re = 0, fin = 0, holding = 0;
        logic rdy_n;
        logic [15:0] h_addr = '0;
        logic [7:0]  h_dout = '0;
        logic        h_we = 1'b0;
        @(negedge clk);
        if (cyc[0] != v.odd) @(negedge clk);
        trig = 1'b1;
        trig_page = v.page;
        rdy = 1'b1;
        while (!fin && steps < 3000) begin
            @(negedge clk);
            steps++;
            trig = 1'b0;
            rdy_n = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (holding) begin
                if (bif.bus_addr !== h_addr || bif.bus_dout !== h_dout || bif.bus_we !== h_we)
                    bad_hold++;
                if (stall_left > 0) begin
                    rdy_n = 1'b0;
                    stall_left--;
                end else begin
                    holding = 0;
                end
            end else if ((!st_r && v.stall_r >= 0 && bif.bus_req && !bif.bus_we &&
                          bif.bus_addr == {v.page, 8'(v.stall_r)} && rd_n == v.stall_r) ||
                         (!st_w && v.stall_w >= 0 && bif.bus_req && bif.bus_we &&
                          wr_n == v.stall_w)) begin
                if (bif.bus_we) st_w = 1; else st_r = 1;
                holding = 1;
                stall_left = 4;
                rdy_n = 1'b0;
                h_addr = bif.bus_addr;
                h_dout = bif.bus_dout;
                h_we = bif.bus_we;
            end
            rdy = rdy_n;
            if (v.retrig && !re && bif.bus_req && !bif.bus_we &&
                bif.bus_addr == {v.page, 8'd100}) begin
                trig = 1'b1;
                trig_page = 8'h07;
                re = 1;
            end
            if (busy) busy_n++;
            if (done) done_n++;
            if (first < 0 && bif.bus_req && !bif.bus_we && bif.bus_addr != DST) first = steps;
            if (bif.bus_req && rdy && !bif.bus_we && bif.bus_addr != DST) begin
                if (bif.bus_addr !== {v.page, 8'(rd_n)}) bad_rd++;
                rd_n++;
            end
            if (bif.bus_req && rdy && bif.bus_we) begin
                if (bif.bus_addr !== DST || bif.bus_dout !== src_byte({v.page, 8'(wr_n)}))
                    bad_wr++;
                wr_n++;
            end
            if (done_n > 0 && !busy) fin = 1;
        end
        trig = 1'b0;
        rdy = 1'b1;
        check({tag, " completes"}, 32'(fin), 1);
        check({tag, " reads"}, rd_n, 256);
        check({tag, " writes"}, wr_n, 256);
        check({tag, " read_addr_errs"}, bad_rd, 0);
        check({tag, " write_data_errs"}, bad_wr, 0);
        check({tag, " done_pulses"}, done_n, 1);
        check({tag, " bus_req_after"}, 32'(bif.bus_req), 0);
        if (!v.rnd) begin
            check({tag, " busy_cycles"}, busy_n, v.exp_busy);
            check({tag, " first_read"}, first, v.exp_first);
        end
        if (v.stall_r >= 0 || v.stall_w >= 0) check({tag, " hold_errs"}, bad_hold, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t rv;
        int wr_n, steps, done_n, busy_n;
        reset = 1'b1;
        trig = 1'b0;
        trig_page = 8'h00;
        rdy = 1'b0;

        vecs[0] = '{8'h02, 1'b0, -1, -1, 1'b0, 1'b0, 515, 3};
        vecs[1] = '{8'h02, 1'b1, -1, -1, 1'b0, 1'b0, 516, 4};
        vecs[2] = '{8'h02, 1'b0, 17, 200, 1'b0, 1'b0, 525, 3};
        vecs[3] = '{8'h02, 1'b0, -1, -1, 1'b1, 1'b0, 515, 3};
        vecs[4] = '{8'hFF, 1'b0, -1, -1, 1'b0, 1'b0, 515, 3};
        vecs[5] = '{8'hFF, 1'b1, 0, 255, 1'b0, 1'b0, 526, 4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset bus_req", 32'(bif.bus_req), 0);
        check("reset bus_we", 32'(bif.bus_we), 0);
        check("reset bus_addr", 32'(bif.bus_addr), 0);
        check("reset bus_dout", 32'(bif.bus_dout), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset state", 32'(dbg_state), 0);
        reset = 1'b0;
        rdy = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

        // Reset while writing idx 50: immediate abort, no done, clean restart.
        @(negedge clk);
        trig = 1'b1;
        trig_page = 8'h02;
        wr_n = 0;
        steps = 0;
        while (steps < 400) begin
            @(negedge clk);
            steps++;
            trig = 1'b0;
            if (bif.bus_req && bif.bus_we) begin
                if (wr_n == 50) break;
                wr_n++;
            end
        end
        check("abort reached idx 50 write", wr_n, 50);
        reset = 1'b1;
        #1;
        check("abort bus_req", 32'(bif.bus_req), 0);
        check("abort bus_we", 32'(bif.bus_we), 0);
        check("abort busy", 32'(busy), 0);
        check("abort done", 32'(done), 0);
        check("abort bus_addr", 32'(bif.bus_addr), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        done_n = 0;
        busy_n = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_n++;
            if (busy) busy_n++;
        end
        check("abort no done", done_n, 0);
        check("abort stays idle", busy_n, 0);
        run_xfer(vecs[0], "restart");

        // Random page and random grant against the copy model.
        for (int k = 0; k < 4; k++) begin
            rv = '{8'h00, 1'b0, -1, -1, 1'b0, 1'b1, 0, 0};
            rv.page = 8'($urandom_range(0, 255));
            if (rv.page == 8'h20) rv.page = 8'h21;
            rv.odd = 1'($urandom_range(0, 1));
            run_xfer(rv, $sformatf("rand%0d_page%02h", k, rv.page));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
